// File: rtl/hs_xfer_sched_if.sv
// Bundle of event, req/ack channel and status signals around the transfer scheduler.
// No logic, zero latency; pure wiring between the scheduler and its environment.
// Backpressure is carried by the four-phase hs_req/hs_ack pair; events never stall.
interface hs_xfer_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   ev_pulse;
  logic           hs_req;
  logic [IDW-1:0] hs_id;
  logic           hs_ack;
  logic           done;
  logic [IDW-1:0] done_id;
  logic           err;
  logic [N-1:0]   ovf;
  logic           busy;

  // Scheduler side: consumes events and ack, drives the channel and status.
  modport master (
    input  ev_pulse,
    input  hs_ack,
    output hs_req,
    output hs_id,
    output done,
    output done_id,
    output err,
    output ovf,
    output busy
  );

  // Environment side: event sources, synchronizer ack and status observers.
  modport slave (
    output ev_pulse,
    output hs_ack,
    input  hs_req,
    input  hs_id,
    input  done,
    input  done_id,
    input  err,
    input  ovf,
    input  busy
  );
endinterface

// File: rtl/hs_xfer_sched.sv
// Round-robin scheduler sharing one four-phase req/ack CDC channel among N event sources.
// Latency: event sampled at edge t -> pending after t, hs_req rises after t+1 when idle.
// Backpressure: one transfer in flight; events queue one deep per source, extras flag ovf.
module hs_xfer_sched #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              sys_rst,
  hs_xfer_sched_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2,
    S_ABORT    = 2'd3
  } state_e;

  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);
  localparam logic [IDW:0]   N_EXT    = (IDW+1)'(N);

  state_e          state_q;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  hs_id_q;
  logic [IDW-1:0]  done_id_q;
  logic            hs_req_q;
  logic            done_q;
  logic            err_q;
  logic            busy_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            gnt_vld;
  logic            gnt_fire;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    cand;

  // Round-robin search starting one past the last granted source, wrapping modulo N.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!gnt_vld && pend_q[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign gnt_fire = (state_q == S_IDLE) && gnt_vld;

  // Pending latches: a new event beats the grant clear; an event hitting a still-pending
  // source that is not being granted this cycle is lost and recorded in ovf.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < N; i++) begin
      if (bus.ev_pulse[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(gnt_fire && (gnt_idx == IDW'(i)))) begin
          ovf_d[i] = 1'b1;
        end
      end else if (gnt_fire && (gnt_idx == IDW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Saturating watchdog increment; saturation is never reached with a legal TIMEOUT.
  assign cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // Channel FSM with registered outputs, plus pending/overflow state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      ovf_q     <= '0;
      last_q    <= LAST_RST;
      hs_id_q   <= '0;
      done_id_q <= '0;
      hs_req_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            hs_id_q  <= gnt_idx;
            last_q   <= gnt_idx;
            hs_req_q <= 1'b1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.hs_ack) begin
            hs_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_WAIT_LOW;
          end else if (cnt_q == TMO_LAST) begin
            hs_req_q <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= S_ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_LOW: begin
          if (!bus.hs_ack) begin
            done_q    <= 1'b1;
            done_id_q <= hs_id_q;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ABORT: begin
          // Wait out the stray ack; the aborted event is dropped, not retried.
          hs_req_q <= 1'b0;
          if (!bus.hs_ack) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          hs_req_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hs_req  = hs_req_q;
  assign bus.hs_id   = hs_id_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.err     = err_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_hs_xfer_sched.sv
// Directed bench for the round-robin CDC transfer scheduler (N=4, TIMEOUT=8).
// One vector per clock: inputs applied after an edge, outputs sampled 1 ns after the next.
// Handshakes are driven by the bench; multi-cycle corner cases use hand-written sequences.
module tb_hs_xfer_sched;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;
  localparam int CW      = 8;
  localparam int NV      = 26;

  logic clk;
  logic sys_rst;

  hs_xfer_sched_if #(.N(N), .IDW(IDW)) bus ();

  hs_xfer_sched #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   ev;
    logic           ack;
    logic           req;
    logic [IDW-1:0] id;
    logic           done;
    logic [IDW-1:0] did;
    logic           err;
    logic           busy;
    logic [N-1:0]   ovf;
  } vec_t;

  vec_t vec [NV];
  int   n_vec;
  int   n_bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [N-1:0] ev);
    bus.ev_pulse = ev;
    step();
    bus.ev_pulse = '0;
  endtask

  // Step until hs_req is seen high, bounded.
  task automatic wait_req(input string name);
    int c;
    c = 0;
    while (!bus.hs_req && c < 40) begin
      step();
      c++;
    end
    chk({name, "_req_seen"}, 32'(bus.hs_req), 32'd1);
  endtask

  // Complete one handshake for the expected source.
  task automatic xfer(input string name, input logic [IDW-1:0] exp_id);
    wait_req(name);
    chk({name, "_id"}, 32'(bus.hs_id), 32'(exp_id));
    bus.hs_ack = 1'b1;
    step();
    chk({name, "_req_low"}, 32'(bus.hs_req), 32'd0);
    bus.hs_ack = 1'b0;
    step();
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    chk({name, "_done_id"}, 32'(bus.done_id), 32'(exp_id));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    //             ev       ack   req   id     done  did    err   busy  ovf
    vec[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000};
    vec[1]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[2]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[3]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[4]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[5]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[6]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    vec[7]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000};
    vec[8]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000};
    // source 0 granted while source 1 piles up: second pulse on 1 overflows
    vec[9]  = '{4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0, 1'b0, 4'b0000};
    vec[10] = '{4'b0010, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1, 4'b0000};
    vec[11] = '{4'b0010, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1, 4'b0010};
    vec[12] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1, 4'b0010};
    vec[13] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0010};
    vec[14] = '{4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010};
    vec[15] = '{4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010};
    vec[16] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0010};
    vec[17] = '{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0010};
    // source 3 pulses again in its own grant cycle: re-armed, no overflow
    vec[18] = '{4'b1000, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0010};
    vec[19] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0010};
    vec[20] = '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0010};
    vec[21] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0010};
    vec[22] = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 4'b0010};
    vec[23] = '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 4'b0010};
    vec[24] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0010};
    vec[25] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 4'b0010};

    // Reset state.
    sys_rst      = 1'b1;
    bus.ev_pulse = '0;
    bus.hs_ack   = 1'b0;
    step();
    step();
    chk("rst_req",  32'(bus.hs_req),  32'd0);
    chk("rst_id",   32'(bus.hs_id),   32'd0);
    chk("rst_done", 32'(bus.done),    32'd0);
    chk("rst_did",  32'(bus.done_id), 32'd0);
    chk("rst_err",  32'(bus.err),     32'd0);
    chk("rst_ovf",  32'(bus.ovf),     32'd0);
    chk("rst_busy", 32'(bus.busy),    32'd0);
    sys_rst = 1'b0;
    step();

    // Table: single event, overflow, set/clear collision.
    for (int v = 0; v < NV; v++) begin
      bus.ev_pulse = vec[v].ev;
      bus.hs_ack   = vec[v].ack;
      step();
      chk($sformatf("v%0d_req", v),  32'(bus.hs_req),  32'(vec[v].req));
      chk($sformatf("v%0d_id", v),   32'(bus.hs_id),   32'(vec[v].id));
      chk($sformatf("v%0d_done", v), 32'(bus.done),    32'(vec[v].done));
      chk($sformatf("v%0d_did", v),  32'(bus.done_id), 32'(vec[v].did));
      chk($sformatf("v%0d_err", v),  32'(bus.err),     32'(vec[v].err));
      chk($sformatf("v%0d_busy", v), 32'(bus.busy),    32'(vec[v].busy));
      chk($sformatf("v%0d_ovf", v),  32'(bus.ovf),     32'(vec[v].ovf));
    end
    bus.ev_pulse = '0;
    bus.hs_ack   = 1'b0;

    // Round-robin fairness over two rounds (last granted is 3).
    for (int r = 0; r < 2; r++) begin
      pulse(4'b1111);
      for (int s = 0; s < N; s++) begin
        xfer($sformatf("rr%0d_%0d", r, s), IDW'(s));
      end
    end
    step();

    // Timeout in REQ: ack held low, next pending source served afterwards.
    pulse(4'b0101);
    wait_req("treq");
    chk("treq_id", 32'(bus.hs_id), 32'd0);
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      chk($sformatf("treq_c%0d_req", c), 32'(bus.hs_req), 32'd1);
      chk($sformatf("treq_c%0d_err", c), 32'(bus.err), 32'd0);
    end
    step();
    chk("treq_err",  32'(bus.err),    32'd1);
    chk("treq_req0", 32'(bus.hs_req), 32'd0);
    chk("treq_busy", 32'(bus.busy),   32'd1);
    chk("treq_done", 32'(bus.done),   32'd0);
    step();
    chk("treq_err_once", 32'(bus.err),  32'd0);
    chk("treq_idle",     32'(bus.busy), 32'd0);
    chk("treq_nodone",   32'(bus.done), 32'd0);
    step();
    chk("treq_next_req", 32'(bus.hs_req), 32'd1);
    chk("treq_next_id",  32'(bus.hs_id),  32'd2);
    bus.hs_ack = 1'b1;
    step();
    bus.hs_ack = 1'b0;
    step();
    chk("treq_next_done", 32'(bus.done),    32'd1);
    chk("treq_next_did",  32'(bus.done_id), 32'd2);
    step();

    // Timeout in WAIT_LOW: ack stuck high for 20 cycles.
    pulse(4'b0010);
    wait_req("twl");
    chk("twl_id", 32'(bus.hs_id), 32'd1);
    bus.hs_ack = 1'b1;
    step();
    chk("twl_entry_req", 32'(bus.hs_req), 32'd0);
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      chk($sformatf("twl_c%0d_err", c), 32'(bus.err), 32'd0);
    end
    step();
    chk("twl_err",  32'(bus.err),  32'd1);
    chk("twl_done", 32'(bus.done), 32'd0);
    for (int c = 0; c < 11; c++) begin
      step();
      chk($sformatf("twl_abort%0d_busy", c), 32'(bus.busy), 32'd1);
      chk($sformatf("twl_abort%0d_err", c),  32'(bus.err),  32'd0);
    end
    bus.hs_ack = 1'b0;
    step();
    chk("twl_release_busy", 32'(bus.busy), 32'd0);
    chk("twl_release_done", 32'(bus.done), 32'd0);
    step();

    // Async reset in REQ with sources 1 and 3 pending.
    pulse(4'b0100);
    wait_req("arst");
    chk("arst_id", 32'(bus.hs_id), 32'd2);
    pulse(4'b1010);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_req_async",  32'(bus.hs_req), 32'd0);
    chk("arst_busy_async", 32'(bus.busy),   32'd0);
    chk("arst_ovf_async",  32'(bus.ovf),    32'd0);
    step();
    sys_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("arst_quiet%0d", c), 32'(bus.hs_req), 32'd0);
    end
    pulse(4'b1111);
    step();
    chk("arst_first_req", 32'(bus.hs_req), 32'd1);
    chk("arst_first_id",  32'(bus.hs_id),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_xfer_sched.md
# hs_xfer_sched

Round-robin scheduler that shares one four-phase req/ack clock-domain-crossing channel between N event sources in the fast (source) clock domain. Each source raises single-cycle event pulses. The block latches them as pending, grants one at a time, and drives the channel's `hs_req`/`hs_id` until the returned, already-synchronized `hs_ack` completes the full handshake. It sits in front of the pulse handshake synchronizer and adds:
- a watchdog timeout;
- per-source overflow flags.

## Interface
Parameters:
- `N`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: width of `hs_id` and `done_id`; must equal ceil(log2(N)).
- `TIMEOUT`, default 255: maximum cycles spent in REQ or WAIT_LOW; legal range 2..(2^CW − 1).
- `CW`, default 8: width of the watchdog counter.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `sys_rst`, input, 1: asynchronous, active-high reset.
- `ev_pulse`, input, N: per-source event pulses, one cycle wide.
- `hs_req`, output, 1: request to the synchronizer channel; registered.
- `hs_id`, output, IDW: index of the granted source; stable while `hs_req`=1; registered.
- `hs_ack`, input, 1: acknowledge, already synchronized into `clk`.
- `done`, output, 1: one-cycle pulse when a transfer completes.
- `done_id`, output, IDW: source of the completed transfer; valid with `done`.
- `err`, output, 1: one-cycle pulse when the watchdog fires.
- `ovf`, output, N: sticky per-source flag, set when an event is lost.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- `pend[N-1:0]` is a one-deep pending latch per source.
  - `ev_pulse[i]`=1 sets `pend[i]`.
  - A grant to source i clears `pend[i]`.
  - If the set and the clear occur in the same cycle, the set wins.
  - If `ev_pulse[i]`=1 while `pend[i]` is already 1 and no grant to i occurs that cycle, the event is dropped and `ovf[i]` is set. `ovf` clears only on reset.
- Arbitration is round-robin. Register `last` holds the index of the most recently granted source; its reset value is N−1. The search starts at `last`+1 and wraps modulo N. The first set `pend` bit wins, and `last` is updated to it on grant.
- State machine: IDLE, REQ, WAIT_LOW, ABORT.
  - IDLE: if any `pend` bit is set, grant a source. Load `hs_id`, set `hs_req`=1, clear that `pend` bit, clear the counter, go to REQ. Otherwise stay in IDLE.
  - REQ: if `hs_ack`=1, set `hs_req`=0, clear the counter, go to WAIT_LOW. Else, if counter = TIMEOUT−1, set `hs_req`=0, pulse `err`, go to ABORT. Else increment the counter.
  - WAIT_LOW: if `hs_ack`=0, pulse `done`, set `done_id`=`hs_id`, go to IDLE. Else, if counter = TIMEOUT−1, pulse `err`, go to ABORT. Else increment the counter.
  - ABORT: `hs_req`=0; stay until `hs_ack`=0, then go to IDLE. No timeout applies in ABORT and no `done` is produced. The aborted event is not retried.
- At most one transfer is in flight. `hs_id` holds its value after a transfer ends, until the next grant.
- `pend` keeps collecting events in every state, including ABORT.
- Counter: CW bits, saturating; wrap-around is impossible because TIMEOUT < 2^CW.

## Timing
- Reset values:
  - `hs_req`=0, `hs_id`=0, `done`=0, `done_id`=0, `err`=0, `ovf`=0, `busy`=0.
  - Internal: `pend`=0, `last`=N−1, counter=0, state IDLE.
- Reset asserted mid-transfer drops `hs_req` asynchronously and discards all pending events.
- Latency:
  - `ev_pulse` sampled at edge t sets `pend` after edge t.
  - `hs_req` rises after edge t+1 if the block was IDLE.
  - A transfer occupies at least 3 cycles: REQ, WAIT_LOW, then the IDLE cycle in which the next grant is made. The minimum grant-to-grant spacing is therefore ack-rise delay + ack-fall delay + 1 cycle.
- `hs_ack` is sampled only in REQ, WAIT_LOW and ABORT; its value in IDLE is ignored.
- `done` and `err` are mutually exclusive and each lasts exactly one cycle.
- Timeout: `err` pulses TIMEOUT cycles after entry to REQ or WAIT_LOW (entry cycle counts as 0) if the awaited `hs_ack` level has not been seen.

## Test plan
- **Single event.** `ev_pulse`=4'b0100 for one cycle; `hs_ack` rises 3 cycles after `hs_req` and falls 3 cycles after `hs_req` drops. Required: `hs_req` rises 2 edges after the pulse with `hs_id`=2; then `done`=1 with `done_id`=2 for one cycle; `busy` returns to 0; `ovf`=0.
- **Round-robin fairness.** `ev_pulse`=4'b1111 for one cycle, then the same four sources pulse again after every completion. Required: grant order 0,1,2,3,0,1,2,3.
- **Set/clear collision and overflow.** Pulse source 1 twice while it is pending (not granted): required `ovf`=4'b0010. Separately, pulse source 3 in its grant cycle: required `pend[3]` stays set and a second transfer with `hs_id`=3 follows; `ovf[3]`=0.
- **Timeout in REQ.** TIMEOUT=8; hold `hs_ack`=0. Required: `err` pulses 8 cycles after `hs_req` rises; `hs_req`=0; state goes to ABORT and then IDLE; no `done`; the next pending source is granted.
- **Timeout in WAIT_LOW.** Hold `hs_ack`=1 for 20 cycles. Required: `err` pulses 8 cycles after WAIT_LOW entry; block stays in ABORT with `busy`=1 until `hs_ack`=0, then `busy`=0.
- **Async reset mid-transfer.** Assert `sys_rst` while in REQ with `pend`=4'b1010. Required: `hs_req`=0 immediately; after release no grants occur without new events, and `last` has restarted so source 0 wins first.
